// File: rtl/fsm_pkg.sv
// Shared definitions for the protobuf field splitter.
// Holds wire-type codes, parser state encoding and datapath widths.
package fsm_pkg;

  localparam int unsigned IDX_W            = 10;
  localparam int unsigned MAX_VARINT_BYTES = 10;
  localparam int unsigned MAX_LEN_BYTES    = 3;
  localparam int unsigned MAX_TAG_BYTES    = 5;
  localparam int unsigned LEN_W            = 21;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned WT_W             = 3;

  localparam logic [WT_W-1:0] WT_VARINT  = 3'd0;
  localparam logic [WT_W-1:0] WT_FIXED64 = 3'd1;
  localparam logic [WT_W-1:0] WT_LEN     = 3'd2;
  localparam logic [WT_W-1:0] WT_FIXED32 = 3'd5;

  typedef enum logic [2:0] {
    S_TAG    = 3'd0,
    S_VARINT = 3'd1,
    S_LEN    = 3'd2,
    S_RAW    = 3'd3,
    S_NOT_V  = 3'd4,
    S_NOT_R  = 3'd5,
    S_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/varint_acc.sv
// Little-endian 7-bit group accumulator with byte counter and overflow flag.
// Ports: clr_i restarts, en_i consumes grp_i; acc_nxt_c is the value including
// the current group, cnt_o the bytes already consumed, ovf_c flags that the
// current byte would exceed limit_i.
module varint_acc
  import fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [6:0]       grp_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [LEN_W-1:0] acc_nxt_c,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_c
);

  logic [LEN_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // Groups landing beyond the accumulator width shift out and are dropped
  assign acc_nxt_c = acc_q | (LEN_W'(grp_i) << (32'(cnt_q) * 32'd7));
  assign ovf_c     = (cnt_q >= limit_i);
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_nxt_c;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_1.sv
// Protobuf input-side field splitter: parses field keys, routes varint payload
// bytes to the varint FIFO and length-delimited payload to the raw FIFO, each
// stamped with a field index, and announces every completed field.
// Ports: in_fifo_* show-ahead byte source; varint_in_* / raw_data_in_* FIFO
// write sides; *_data_valid / *_data_accepted completion handshakes;
// msg_clr aborts and clears; parse_error is a sticky malformed-input flag.
// Build option: FSM_1_FIXED_WIRE_EN routes wire types 1 (8 bytes) and
// 5 (4 bytes) to the raw FIFO; otherwise they are parse errors.
module fsm_1
  import fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_clr,
  input  logic             in_fifo_empty,
  input  logic [7:0]       in_fifo_q,
  output logic             in_fifo_pop,
  input  logic             varint_in_fifo_full,
  output logic             varint_in_fifo_clr,
  output logic             varint_in_fifo_push,
  output logic [7:0]       varint_in_fifo_data,
  output logic [IDX_W-1:0] varint_in_index_data,
  input  logic             raw_data_in_fifo_full,
  output logic             raw_data_in_fifo_clr,
  output logic             raw_data_in_fifo_push,
  output logic [7:0]       raw_data_in_fifo_data,
  output logic [IDX_W-1:0] raw_data_in_index_data,
  output logic             varint_data_valid,
  output logic             raw_data_valid,
  input  logic             varint_data_accepted,
  input  logic             raw_data_accepted,
  output logic             parse_error
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WT_W-1:0]  wt_q, wt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             vv_q, vv_d, rv_q, rv_d, perr_q, perr_d, clr_q;

  logic             pop_c, vpush_c, rpush_c, acc_en_c, acc_clr_c, acc_ovf;
  logic [CNT_W-1:0] limit_c, acc_cnt;
  logic [LEN_W-1:0] acc_nxt;
  logic [WT_W-1:0]  wt_eff_c;

  varint_acc u_acc (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (acc_clr_c),
    .en_i      (acc_en_c),
    .grp_i     (in_fifo_q[6:0]),
    .limit_i   (limit_c),
    .acc_nxt_c (acc_nxt),
    .cnt_o     (acc_cnt),
    .ovf_c     (acc_ovf)
  );

  // Wire type comes from the first key byte even when the key is one byte long
  assign wt_eff_c  = (acc_cnt == '0) ? in_fifo_q[WT_W-1:0] : wt_q;
  // Every state change restarts the accumulator
  assign acc_clr_c = msg_clr | (state_d != state_q);

  // Next-state, transfer and handshake logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wt_d     = wt_q;
    rem_d    = rem_q;
    vv_d     = vv_q;
    rv_d     = rv_q;
    pop_c    = 1'b0;
    vpush_c  = 1'b0;
    rpush_c  = 1'b0;
    acc_en_c = 1'b0;
    limit_c  = CNT_W'(MAX_TAG_BYTES);

    case (state_q)
      S_TAG: begin
        if (!in_fifo_empty) begin
          pop_c    = 1'b1;
          acc_en_c = 1'b1;
          if (acc_cnt == '0) wt_d = in_fifo_q[WT_W-1:0];
          if (acc_ovf) begin
            state_d = S_ERR;
          end else if (!in_fifo_q[7]) begin
            case (wt_eff_c)
              WT_VARINT: state_d = S_VARINT;
              WT_LEN:    state_d = S_LEN;
`ifdef FSM_1_FIXED_WIRE_EN
              WT_FIXED64: begin
                rem_d   = LEN_W'(8);
                state_d = S_RAW;
              end
              WT_FIXED32: begin
                rem_d   = LEN_W'(4);
                state_d = S_RAW;
              end
`else
              WT_FIXED64, WT_FIXED32: state_d = S_ERR;
`endif
              default:   state_d = S_ERR;
            endcase
          end
        end
      end
      S_VARINT: begin
        limit_c = CNT_W'(MAX_VARINT_BYTES);
        if (!in_fifo_empty && !varint_in_fifo_full) begin
          pop_c    = 1'b1;
          acc_en_c = 1'b1;
          if (acc_ovf) begin
            state_d = S_ERR;
          end else begin
            vpush_c = 1'b1;
            if (!in_fifo_q[7]) state_d = S_NOT_V;
          end
        end
      end
      S_LEN: begin
        limit_c = CNT_W'(MAX_LEN_BYTES);
        if (!in_fifo_empty) begin
          pop_c    = 1'b1;
          acc_en_c = 1'b1;
          if (acc_ovf) begin
            state_d = S_ERR;
          end else if (!in_fifo_q[7]) begin
            if (acc_nxt == '0) begin
              state_d = S_NOT_R;
            end else begin
              rem_d   = acc_nxt;
              state_d = S_RAW;
            end
          end
        end
      end
      S_RAW: begin
        if (!in_fifo_empty && !raw_data_in_fifo_full) begin
          pop_c   = 1'b1;
          rpush_c = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_NOT_R;
        end
      end
      S_NOT_V: begin
        if (!vv_q) begin
          vv_d = 1'b1;
        end else if (varint_data_accepted) begin
          vv_d    = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_TAG;
        end
      end
      S_NOT_R: begin
        if (!rv_q) begin
          rv_d = 1'b1;
        end else if (raw_data_accepted) begin
          rv_d    = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_TAG;
        end
      end
      S_ERR: begin
      end
      default: state_d = S_TAG;
    endcase

    perr_d = perr_q | (state_d == S_ERR);

    if (msg_clr) begin
      state_d = S_TAG;
      idx_d   = '0;
      rem_d   = '0;
      vv_d    = 1'b0;
      rv_d    = 1'b0;
      perr_d  = 1'b0;
    end

    // No byte moves while clearing or while held in reset
    if (msg_clr || !reset) begin
      pop_c    = 1'b0;
      vpush_c  = 1'b0;
      rpush_c  = 1'b0;
      acc_en_c = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_TAG;
      idx_q   <= '0;
      wt_q    <= '0;
      rem_q   <= '0;
      vv_q    <= 1'b0;
      rv_q    <= 1'b0;
      perr_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wt_q    <= wt_d;
      rem_q   <= rem_d;
      vv_q    <= vv_d;
      rv_q    <= rv_d;
      perr_q  <= perr_d;
      clr_q   <= msg_clr;
    end
  end

  assign in_fifo_pop            = pop_c;
  assign varint_in_fifo_push    = vpush_c;
  assign raw_data_in_fifo_push  = rpush_c;
  assign varint_in_fifo_data    = in_fifo_q;
  assign raw_data_in_fifo_data  = in_fifo_q;
  assign varint_in_index_data   = idx_q;
  assign raw_data_in_index_data = idx_q;
  assign varint_in_fifo_clr     = clr_q;
  assign raw_data_in_fifo_clr   = clr_q;
  assign varint_data_valid      = vv_q;
  assign raw_data_valid         = rv_q;
  assign parse_error            = perr_q;

endmodule

// File: tb/tb_fsm_1.sv
// Scoreboard bench for fsm_1: stimulus encodes protobuf fields into a modelled
// input FIFO and queues the expected pushes and completion events; a negedge
// monitor pops and compares whenever the DUT pushes or completes a handshake.
module tb_fsm_1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       msg_clr = 1'b0;
  logic       in_fifo_empty = 1'b1;
  logic [7:0] in_fifo_q = 8'h00;
  logic       varint_in_fifo_full = 1'b0;
  logic       raw_data_in_fifo_full = 1'b0;
  logic       varint_data_accepted = 1'b0;
  logic       raw_data_accepted = 1'b0;

  logic       in_fifo_pop;
  logic       varint_in_fifo_clr, varint_in_fifo_push;
  logic [7:0] varint_in_fifo_data;
  logic [9:0] varint_in_index_data;
  logic       raw_data_in_fifo_clr, raw_data_in_fifo_push;
  logic [7:0] raw_data_in_fifo_data;
  logic [9:0] raw_data_in_index_data;
  logic       varint_data_valid, raw_data_valid, parse_error;

  fsm_1 dut (
    .clk                    (clk),
    .reset                  (reset),
    .msg_clr                (msg_clr),
    .in_fifo_empty          (in_fifo_empty),
    .in_fifo_q              (in_fifo_q),
    .in_fifo_pop            (in_fifo_pop),
    .varint_in_fifo_full    (varint_in_fifo_full),
    .varint_in_fifo_clr     (varint_in_fifo_clr),
    .varint_in_fifo_push    (varint_in_fifo_push),
    .varint_in_fifo_data    (varint_in_fifo_data),
    .varint_in_index_data   (varint_in_index_data),
    .raw_data_in_fifo_full  (raw_data_in_fifo_full),
    .raw_data_in_fifo_clr   (raw_data_in_fifo_clr),
    .raw_data_in_fifo_push  (raw_data_in_fifo_push),
    .raw_data_in_fifo_data  (raw_data_in_fifo_data),
    .raw_data_in_index_data (raw_data_in_index_data),
    .varint_data_valid      (varint_data_valid),
    .raw_data_valid         (raw_data_valid),
    .varint_data_accepted   (varint_data_accepted),
    .raw_data_accepted      (raw_data_accepted),
    .parse_error            (parse_error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  bq_t         in_q;
  logic [17:0] exp_v[$];
  logic [17:0] exp_r[$];
  logic [10:0] exp_ev[$];
  int          raw_cyc[$];
  int          m_idx = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ev_seen = 0;
  int          full_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  function automatic bq_t enc(input logic [63:0] v);
    bq_t r;
    do begin
      logic [7:0] b;
      b = {1'b0, v[6:0]};
      v = v >> 7;
      if (v != 64'd0) b[7] = 1'b1;
      r.push_back(b);
    end while (v != 64'd0);
    return r;
  endfunction

  task automatic push_key(input logic [31:0] fnum, input logic [2:0] wt);
    bq_t k;
    k = enc((64'(fnum) << 3) | 64'(wt));
    foreach (k[i]) in_q.push_back(k[i]);
  endtask

  task automatic send_varint(input logic [31:0] fnum, input logic [63:0] val);
    bq_t p;
    push_key(fnum, 3'd0);
    p = enc(val);
    foreach (p[i]) begin
      in_q.push_back(p[i]);
      exp_v.push_back({10'(m_idx), p[i]});
    end
    exp_ev.push_back({1'b0, 10'(m_idx)});
    m_idx = (m_idx + 1) % 1024;
  endtask

  task automatic send_len(input logic [31:0] fnum, input bq_t pl);
    bq_t l;
    push_key(fnum, 3'd2);
    l = enc(64'(pl.size()));
    foreach (l[i]) in_q.push_back(l[i]);
    foreach (pl[i]) begin
      in_q.push_back(pl[i]);
      exp_r.push_back({10'(m_idx), pl[i]});
    end
    exp_ev.push_back({1'b1, 10'(m_idx)});
    m_idx = (m_idx + 1) % 1024;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_v.size() != 0 || exp_r.size() != 0 ||
            exp_ev.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= budget), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Show-ahead input FIFO model: a pop seen before the edge consumes the head
  initial begin : ififo
    logic p;
    forever begin
      @(negedge clk);
      p = in_fifo_pop;
      @(posedge clk);
      #1;
      if (p && in_q.size() > 0) void'(in_q.pop_front());
      in_fifo_empty = (in_q.size() == 0);
      in_fifo_q = (in_q.size() > 0) ? in_q[0] : 8'h00;
    end
  end

  // Random downstream acks and FIFO back-pressure
  initial begin : hs
    forever begin
      @(posedge clk);
      #1;
      varint_data_accepted = ($urandom_range(0, 2) == 0);
      raw_data_accepted    = ($urandom_range(0, 2) == 0);
      case (full_mode)
        1: begin
          varint_in_fifo_full   = ($urandom_range(0, 3) == 0);
          raw_data_in_fifo_full = ($urandom_range(0, 3) == 0);
        end
        2: begin
          varint_in_fifo_full   = 1'b0;
          raw_data_in_fifo_full = 1'b1;
        end
        default: begin
          varint_in_fifo_full   = 1'b0;
          raw_data_in_fifo_full = 1'b0;
        end
      endcase
    end
  end

  // Monitor: pops expectations when the DUT pushes or completes a handshake
  logic [17:0] mon_e;
  logic [10:0] mon_ev;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (varint_in_fifo_push) begin
        chk("vpush_with_pop", 64'(in_fifo_pop), 64'd1);
        chk("vpush_not_full", 64'(varint_in_fifo_full), 64'd0);
        if (exp_v.size() == 0) fail_now("vpush_unexpected");
        else begin
          mon_e = exp_v.pop_front();
          chk("vpush_idx_data", 64'({varint_in_index_data, varint_in_fifo_data}), 64'(mon_e));
        end
      end
      if (raw_data_in_fifo_push) begin
        raw_cyc.push_back(cyc);
        chk("rpush_with_pop", 64'(in_fifo_pop), 64'd1);
        chk("rpush_not_full", 64'(raw_data_in_fifo_full), 64'd0);
        if (exp_r.size() == 0) fail_now("rpush_unexpected");
        else begin
          mon_e = exp_r.pop_front();
          chk("rpush_idx_data", 64'({raw_data_in_index_data, raw_data_in_fifo_data}), 64'(mon_e));
        end
      end
      if (varint_data_valid && raw_data_valid) fail_now("both_valids_high");
      if (varint_data_valid && varint_data_accepted) begin
        ev_seen++;
        if (exp_ev.size() == 0) fail_now("vvalid_unexpected");
        else begin
          mon_ev = exp_ev.pop_front();
          chk("vvalid_event", 64'({1'b0, varint_in_index_data}), 64'(mon_ev));
        end
      end
      if (raw_data_valid && raw_data_accepted) begin
        ev_seen++;
        if (exp_ev.size() == 0) fail_now("rvalid_unexpected");
        else begin
          mon_ev = exp_ev.pop_front();
          chk("rvalid_event", 64'({1'b1, raw_data_in_index_data}), 64'(mon_ev));
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bq_t pl;
    int  n, k, ev0;

    // First field is queued while reset is still asserted
    repeat (2) @(posedge clk);
    #1;
    send_varint(32'd1, 64'd150);
    repeat (2) @(negedge clk);
    chk("rst_pop", 64'(in_fifo_pop), 64'd0);
    chk("rst_vvalid", 64'(varint_data_valid), 64'd0);
    chk("rst_rvalid", 64'(raw_data_valid), 64'd0);
    chk("rst_perr", 64'(parse_error), 64'd0);
    chk("rst_clr", 64'({varint_in_fifo_clr, raw_data_in_fifo_clr}), 64'd0);
    chk("rst_push", 64'({varint_in_fifo_push, raw_data_in_fifo_push}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_idle(200);

    // Length-delimited payload at one byte per cycle
    raw_cyc.delete();
    pl = {8'h41, 8'h42, 8'h43};
    send_len(32'd2, pl);
    wait_idle(200);
    chk("raw3_count", 64'(raw_cyc.size()), 64'd3);
    if (raw_cyc.size() == 3) chk("raw3_rate", 64'(raw_cyc[2] - raw_cyc[0]), 64'd2);

    // Empty raw field followed by a varint
    pl.delete();
    send_len(32'd1, pl);
    send_varint(32'd1, 64'd1);
    wait_idle(200);

    // Raw FIFO full mid-payload
    raw_cyc.delete();
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    send_len(32'd3, pl);
    n = 0;
    while (raw_cyc.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached", 64'(raw_cyc.size() >= 3), 64'd1);
    full_mode = 2;
    n = 0;
    k = 0;
    while (k < 5 && n < 20) begin
      @(negedge clk);
      n++;
      if (raw_data_in_fifo_full) begin
        k++;
        chk("stall_pop", 64'(in_fifo_pop), 64'd0);
        chk("stall_push", 64'(raw_data_in_fifo_push), 64'd0);
      end
    end
    full_mode = 0;
    wait_idle(300);

    // Wire type 5 key
`ifdef FSM_1_FIXED_WIRE_EN
    in_q.push_back(8'h0D);
    pl = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (pl[i]) begin
      in_q.push_back(pl[i]);
      exp_r.push_back({10'(m_idx), pl[i]});
    end
    exp_ev.push_back({1'b1, 10'(m_idx)});
    m_idx = (m_idx + 1) % 1024;
    wait_idle(200);
    chk("fixed32_no_err", 64'(parse_error), 64'd0);
`else
    pl = {8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (pl[i]) in_q.push_back(pl[i]);
    n = 0;
    while (!parse_error && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("err_set", 64'(parse_error), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("err_no_pop", 64'(in_q.size()), 64'd4);
    in_q.delete();
    msg_clr = 1'b1;
    @(posedge clk);
    #1;
    msg_clr = 1'b0;
    @(negedge clk);
    chk("clr_pulse", 64'({varint_in_fifo_clr, raw_data_in_fifo_clr}), 64'd3);
    chk("clr_perr", 64'(parse_error), 64'd0);
    @(negedge clk);
    chk("clr_single", 64'({varint_in_fifo_clr, raw_data_in_fifo_clr}), 64'd0);
    m_idx = 0;
    @(posedge clk);
    #1;
    send_varint(32'd1, 64'd1);
    wait_idle(200);
`endif

    // Back-to-back minimal varint fields across the index wrap
    ev0 = ev_seen;
    repeat (1026) send_varint(32'd1, 64'd0);
    wait_idle(20000);
    chk("wrap_events", 64'(ev_seen - ev0), 64'd1026);

    // Randomised fields under random back-pressure
    full_mode = 1;
    repeat (150) begin
      if ($urandom_range(0, 1) == 0) begin
        send_varint($urandom >> $urandom_range(3, 31),
                    {$urandom, $urandom} >> $urandom_range(0, 63));
      end else begin
        pl.delete();
        n = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 300) : $urandom_range(0, 8);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        send_len($urandom >> $urandom_range(3, 31), pl);
      end
    end
    wait_idle(40000);
    full_mode = 0;

    chk("end_queues_empty", 64'(exp_v.size() + exp_r.size() + exp_ev.size()), 64'd0);
    chk("end_perr", 64'(parse_error), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
